// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and hex-to-segment decode for the seven-segment scan driver
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] CSN_OFF = 8'hFF;

    // Active-low a..g patterns for hex digits 0..F (bit0 = a, bit6 = g).
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// rtl/seg7_scan_timer.sv - digit-slot prescaler and digit index for the scan driver
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int GHOST_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [2:0] digit_idx,
    output logic       slot_end,
    output logic       in_ghost,
    output logic       frame_wrap
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc;
    logic          first_slot;

    assign slot_end   = (presc == PW'(SCAN_DIV - 1));
    assign in_ghost   = (presc < PW'(GHOST_CYCLES));
    // The first slot end after reset also reloads, so valid data shows without waiting a full frame.
    assign frame_wrap = slot_end && ((digit_idx == 3'd7) || first_slot);

    // Prescaler wraps at the slot end, which advances the digit index mod 8.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc      <= '0;
            digit_idx  <= 3'd0;
            first_slot <= 1'b1;
        end else if (slot_end) begin
            presc      <= '0;
            digit_idx  <= digit_idx + 3'd1;
            first_slot <= 1'b0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - eight-digit multiplexed seven-segment driver; SEG7_LZ_BLANK_EN adds leading-zero blanking
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int GHOST_CYCLES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    input  logic [7:0]  digit_en,
    output logic [7:0]  num_csn,
    output logic [7:0]  num_an,
    output logic        frame_tick
);

    logic [2:0]  digit_idx;
    logic        slot_end;
    logic        in_ghost;
    logic        frame_wrap;

    logic [31:0] snap_data;
    logic [7:0]  snap_dp;
    logic [7:0]  snap_en;
    logic [7:0]  blank;
    logic [3:0]  nib;
    logic        lit;

    seg7_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .GHOST_CYCLES (GHOST_CYCLES)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .digit_idx  (digit_idx),
        .slot_end   (slot_end),
        .in_ghost   (in_ghost),
        .frame_wrap (frame_wrap)
    );

    // Frame-coherent snapshot: inputs only change what is shown at a frame reload.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_data <= '0;
            snap_dp   <= '0;
            snap_en   <= '0;
        end else if (frame_wrap) begin
            snap_data <= data;
            snap_dp   <= dp;
            snap_en   <= digit_en;
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [2:0] msd;

    // Digits above the highest nonzero nibble go dark unless their decimal point is lit.
    always_comb begin
        msd   = 3'd0;
        blank = '0;
        for (int i = 1; i < 8; i++) begin
            if (snap_data[i*4 +: 4] != 4'h0) msd = 3'(i);
        end
        for (int i = 0; i < 8; i++) begin
            blank[i] = (3'(i) > msd) && !snap_dp[i];
        end
    end
`else
    assign blank = '0;
`endif

    assign nib = snap_data[digit_idx*4 +: 4];
    assign lit = !in_ghost && snap_en[digit_idx] && !blank[digit_idx];

    // Registered pins; the ghost interval and disabled digits drive everything off.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            num_csn    <= CSN_OFF;
            num_an     <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            if (lit) begin
                num_csn <= ~(8'd1 << digit_idx);
                num_an  <= {~snap_dp[digit_idx], hex2seg(nib)};
            end else begin
                num_csn <= CSN_OFF;
                num_an  <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver; SEG7_LZ_BLANK_EN enables the blanking cases
module tb_seg7_scan_driver;

    localparam int SD = 8;
    localparam int GC = 2;
    localparam int FRAME = 8 * SD;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  digit_en;
    logic [7:0]  num_csn;
    logic [7:0]  num_an;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    int          m_cyc;
    logic [31:0] m_data;
    logic [7:0]  m_dp;
    logic [7:0]  m_en;
    logic [16:0] sb_q [$];

    logic [7:0] seg_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    logic [7:0] frame1_an [8] = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

    seg7_scan_driver #(
        .SCAN_DIV     (SD),
        .GHOST_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .data       (data),
        .dp         (dp),
        .digit_en   (digit_en),
        .num_csn    (num_csn),
        .num_an     (num_an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    function automatic logic [16:0] expect_out(input int p, input int k, input logic cap,
                                               input logic [31:0] sd, input logic [7:0] sp,
                                               input logic [7:0] se);
        logic [3:0] nib;
        logic [7:0] csn;
        logic       blk;
        int         msd;
        blk = 1'b0;
        msd = 0;
`ifdef SEG7_LZ_BLANK_EN
        for (int i = 0; i < 8; i++) if (((sd >> (4 * i)) & 32'hF) != 0) msd = i;
        blk = (k > msd) && !sp[k];
`endif
        if (p < GC || !se[k] || blk) return {cap, 8'hFF, 8'hFF};
        nib = 4'((sd >> (4 * k)) & 32'hF);
        csn = 8'hFF;
        csn[k] = 1'b0;
        return {cap, csn, ~sp[k], seg_tab[nib][6:0]};
    endfunction

    task automatic step();
        int   p;
        int   k;
        logic cap;
        p   = m_cyc % SD;
        k   = (m_cyc / SD) % 8;
        cap = (p == SD - 1) && (m_cyc == SD - 1 || k == 7);
        sb_q.push_back(expect_out(p, k, cap, m_data, m_dp, m_en));
        if (cap) begin
            m_data = data;
            m_dp   = dp;
            m_en   = digit_en;
        end
        @(posedge clk);
        #1;
        m_cyc++;
        if (sb_q.size() > 0) check("scan", {15'd0, frame_tick, num_csn, num_an}, {15'd0, sb_q.pop_front()});
        check("one_low", 32'($countones(~num_csn) <= 1), 32'd1);
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((m_cyc % FRAME) != 0 && n < 2 * FRAME);
        if (n >= 2 * FRAME) check("sync_timeout", 32'(n), 32'(FRAME));
    endtask

    task automatic check_slot(input string tag, input int k, input logic [7:0] ecsn, input logic [7:0] ean);
        int n;
        n = 0;
        while (((m_cyc - 1) % FRAME) != (SD * k + GC) && n < 2 * FRAME) begin
            step();
            n++;
        end
        if (n >= 2 * FRAME) check({tag, "_timeout"}, 32'(n), 32'd0);
        else check(tag, {16'd0, num_csn, num_an}, {16'd0, ecsn, ean});
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check("rst_async", {15'd0, frame_tick, num_csn, num_an}, {15'd0, 1'b0, 8'hFF, 8'hFF});
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        m_cyc  = 0;
        m_data = '0;
        m_dp   = '0;
        m_en   = '0;
        sb_q.delete();
    endtask

    initial begin
        resetn   = 1'b1;
        data     = 32'h0123_4567;
        dp       = 8'h00;
        digit_en = 8'hFF;
        #2;
        do_reset();

        // First reload lands at the first slot end, then a full frame of 7..0
        repeat (SD) step();
        check("first_tick", {31'd0, frame_tick}, 32'd1);
        sync_frame();
        for (int k = 0; k < 8; k++) begin
            check_slot("frame1", k, ~(8'd1 << k), frame1_an[k]);
        end

        // Decimal point on digit 0 only
        dp   = 8'h01;
        data = 32'hFFFF_FFFF;
        sync_frame();
        sync_frame();
        check_slot("dp_d0", 0, 8'hFE, 8'h0E);
        check_slot("dp_d5", 5, 8'hDF, 8'h8E);

        // Mid-frame change stays hidden until the next reload
        sync_frame();
        repeat (20) step();
        data = 32'h89AB_CDEF;
        dp   = 8'h00;
        check_slot("old_d4", 4, 8'hEF, 8'h8E);
        sync_frame();
        check_slot("new_d0", 0, 8'hFE, 8'h8E);
        check_slot("new_d4", 4, 8'hEF, 8'h83);

        // Upper four digits disabled
        digit_en = 8'h0F;
        sync_frame();
        for (int i = 0; i < FRAME; i++) begin
            step();
            check("csn_hi", {28'd0, num_csn[7:4]}, 32'hF);
        end

        // Reset in the middle of a slot
        digit_en = 8'hFF;
        data     = 32'h0123_4567;
        sync_frame();
        repeat (SD + 4) step();
        do_reset();
        repeat (SD) step();
        check("rst_tick", {31'd0, frame_tick}, 32'd1);
        sync_frame();
        check_slot("rst_d0", 0, 8'hFE, 8'hF8);
        sync_frame();

`ifdef SEG7_LZ_BLANK_EN
        data = 32'h0000_00A0;
        sync_frame();
        sync_frame();
        check_slot("lz_d0", 0, 8'hFE, 8'hC0);
        check_slot("lz_d1", 1, 8'hFD, 8'h88);
        check_slot("lz_d2", 2, 8'hFF, 8'hFF);
        check_slot("lz_d7", 7, 8'hFF, 8'hFF);
        data = 32'h0000_0000;
        sync_frame();
        sync_frame();
        check_slot("zero_d0", 0, 8'hFE, 8'hC0);
        check_slot("zero_d1", 1, 8'hFF, 8'hFF);
        sync_frame();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
